// File: rtl/hex_display_mux_if.sv
// hex_display_mux_if: display data, controls and multiplexed segment/grid outputs
interface hex_display_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic [4*NUM_DIGITS-1:0] in;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [BRIGHT_W-1:0]     brightness;
    logic [7:0]              hex_seg;
    logic [NUM_DIGITS-1:0]   hex_grid;
    logic                    frame_done;

    modport master (
        output in, dp, load, lz_blank, blink_mask, brightness,
        input  hex_seg, hex_grid, frame_done
    );

    modport slave (
        input  in, dp, load, lz_blank, blink_mask, brightness,
        output hex_seg, hex_grid, frame_done
    );
endinterface

// File: rtl/hex_display_mux.sv
// hex_display_mux: multiplexed 7-segment driver with tear-free load, blanking, blink and PWM
module hex_display_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_LOG2    = 16,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input logic             clk,
    input logic             reset_n,
    hex_display_mux_if.slave bus
);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic [SLOT_LOG2-1:0]    slot;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] act_in, pend_in;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic                    pend_valid;
    logic                    slot_wrap, frame_end, grid_en, seen;
    logic [NUM_DIGITS-1:0]   blank;
    logic [BRIGHT_W-1:0]     phase;
    logic [3:0]              nib;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   grid_next;

    assign slot_wrap = &slot;
    assign frame_end = slot_wrap && idx == IDX_W'(NUM_DIGITS - 1);

    // Scan timing: slot counter, digit index and blink phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot        <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot <= slot + 1'b1;
            if (slot_wrap)
                idx <= frame_end ? '0 : idx + 1'b1;
            if (frame_end) begin
                blink_cnt <= blink_cnt == BLK_W'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1))
                    blink_phase <= ~blink_phase;
            end
        end
    end

    // Double buffer: loads park in pending and reach active only at a frame boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_in     <= '0;
            act_dp     <= '0;
            pend_in    <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (bus.load && frame_end) begin
            act_in     <= bus.in;
            act_dp     <= bus.dp;
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pend_in    <= bus.in;
            pend_dp    <= bus.dp;
            pend_valid <= 1'b1;
        end else if (frame_end && pend_valid) begin
            act_in     <= pend_in;
            act_dp     <= pend_dp;
            pend_valid <= 1'b0;
        end
    end

    // Leading-zero mask: blank from the top digit until a non-zero nibble or lit dp
    always_comb begin
        seen  = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen     = seen | (act_in[4*i +: 4] != 4'd0) | act_dp[i];
            blank[i] = bus.lz_blank & ~seen & (i != 0);
        end
    end

    assign phase     = slot[SLOT_LOG2-1 -: BRIGHT_W];
    assign grid_en   = (&bus.brightness) || (phase < bus.brightness);
    assign nib       = act_in[4*idx +: 4];
    assign seg_next  = blank[idx] ? 8'hFF : (FONT[nib] & ~{act_dp[idx], 7'b0});
    assign grid_next = (grid_en && !(blink_phase && bus.blink_mask[idx])) ?
                       ~(NUM_DIGITS'(1) << idx) : '1;

    // Output register: segments and grid change on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.hex_seg    <= 8'hFF;
            bus.hex_grid   <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.hex_seg    <= seg_next;
            bus.hex_grid   <= grid_next;
            bus.frame_done <= frame_end;
        end
    end
endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
- Parametrised multiplexed 7-segment driver; next generation of the 4-digit HexDriver used on the HEX A/B banks.
- Generalised digit count; adds frame-synchronous tear-free loading, leading-zero blanking, per-digit blink and PWM brightness.
- Instantiated under the top level to show score, timer (mm:ss) and debug nibbles. Runs on the 100 MHz board clock.

Parameters:
- NUM_DIGITS, 4, number of digits and grid lines (1..8).
- SLOT_LOG2, 16, log2 of the cycles each digit is driven per frame (slot = 2^SLOT_LOG2 cycles).
- BRIGHT_W, 3, brightness control width; must be <= SLOT_LOG2.
- BLINK_FRAMES, 64, frames per blink half-period (>= 1).

Ports:
- clk  in  1  board clock.
- reset_n  in  1  synchronous, active-low reset.
- in  in  4*NUM_DIGITS  hex nibbles; digit i = in[4i+3:4i], digit 0 rightmost.
- dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures in/dp.
- lz_blank  in  1  1 = enable leading-zero blanking.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- brightness  in  BRIGHT_W  duty control; all-ones = 100 %.
- hex_seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- hex_grid  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all ones.
- frame_done  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1's slot.

Behaviour:
- Reset (reset_n=0 at a clk edge): hex_seg=8'hFF, hex_grid=all ones, frame_done=0. Slot counter, digit index, blink counter and blink phase = 0. Active and pending registers = 0. Pending-valid = 0.
- Reset mid-frame aborts the scan immediately. Any pending load is discarded.
- Slot counter increments every cycle and wraps at 2^SLOT_LOG2-1. On wrap, digit index advances, wrapping NUM_DIGITS-1 -> 0.
- Frame end is the cycle where the slot counter wraps with index = NUM_DIGITS-1. frame_done is registered from frame end and asserts on that same cycle's output.
- Loading:
  - load=1 writes in/dp into pending and sets pending-valid.
  - At frame end, if pending-valid, pending is copied to active and pending-valid clears.
  - If load coincides with frame end, the new in/dp go directly to active and pending-valid clears.
  - Displayed data changes only between frames (no tearing).
- Decode uses the standard active-low font: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E. The dp bit is cleared to 0 when active dp[i]=1.
- Leading-zero blanking (lz_blank=1): scanning from digit NUM_DIGITS-1 down, digits with nibble 0 and dp 0 are blanked until the first non-zero nibble or set dp. Digit 0 is never blanked. Blanked means hex_seg=FF.
- Blink:
  - The blink counter counts frame ends. At BLINK_FRAMES-1 it wraps and toggles blink phase.
  - When blink phase=1, digits with blink_mask[i]=1 drive hex_grid[i]=1 (off).
  - blink_mask and lz_blank are sampled live, not via load.
- Brightness:
  - phase = slot counter[SLOT_LOG2-1 -: BRIGHT_W].
  - Grid is enabled when brightness is all ones, or when phase < brightness.
  - brightness=0 means the grid is always off.
- Output pipeline: hex_seg/hex_grid are registered, one-cycle latency from index/phase.
  - Both update on the same edge, so the grid never overlaps two digits.
  - Exactly one grid bit is 0 whenever the digit is enabled.
- Arithmetic: all counters are unsigned and wrap. No width truncation beyond the stated fields.

Test Plan:
- Bench parameters: NUM_DIGITS=4, SLOT_LOG2=4, BRIGHT_W=2, BLINK_FRAMES=2.
- Reset: hold reset_n=0 for 3 cycles -> hex_seg=FF, hex_grid=1111, frame_done=0. Release -> first grid 1110 after 1 cycle.
- Load and decode: load in=16'h1F08, dp=0000, brightness=11 -> from the next frame, per slot segments are digit0=80, digit1=C0, digit2=8E, digit3=F9. frame_done pulses every 64 cycles.
- Tear-free load: load in=16'h2222 mid-frame, then in=16'h3333 two cycles later -> current frame unchanged. The next frame shows all B0. Load on the exact frame_done cycle -> the new value appears in the following frame.
- Leading zeros: in=16'h0050, lz_blank=1 -> digits 3 and 2 show FF, digit1=92, digit0=C0. Then in=16'h0000 -> only digit0 shows C0. dp=0100 with in=16'h0050 -> digit2 shows 40, digit3 FF.
- Blink and brightness:
  - blink_mask=0001 -> digit0's grid is off for frames 2-3, on for 0-1 and 4-5.
  - brightness=01 -> grid low 4 of 16 cycles per slot.
  - brightness=00 -> hex_grid stays 1111.
- Reset mid-frame with a pending load -> after release, active data is 0 (0000 shown, or C0 on digit0 only if lz_blank=1).
